// File: rtl/alu_resp_misr.sv
// alu_resp_misr: response compactor for the 8-bit ALU.
// Folds alu_out into a MISR signature over a programmed window that starts
// SKIP cycles after start, then compares the result with a golden value.
module alu_resp_misr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h1D,
  parameter logic [WIDTH-1:0] SEED  = 8'h00,
  parameter int               SKIP  = 2,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SKIP    = 2'd1;
  localparam logic [1:0] ST_COMPACT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // skip_cnt is 4 bits wide, which bounds SKIP to 0..15
  localparam logic [3:0]       SKIP_LD   = 4'(SKIP);
  localparam bit               SKIP_ZERO = (SKIP == 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // One MISR step: shift left, apply feedback taps when the MSB falls out,
  // then xor in the new response word.
  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] sig,
                                                 input logic [WIDTH-1:0] din);
    logic [WIDTH-1:0] fb;
    if (sig[WIDTH-1]) begin
      fb = POLY;
    end else begin
      fb = {WIDTH{1'b0}};
    end
    return {sig[WIDTH-2:0], 1'b0} ^ fb ^ din;
  endfunction

  logic [1:0]       state_r;
  logic [3:0]       skip_cnt_r;
  logic [CNT_W-1:0] vec_cnt_r;

  logic [1:0]       state_s;
  logic [3:0]       skip_cnt_s;
  logic [CNT_W-1:0] vec_cnt_s;
  logic [WIDTH-1:0] sig_s;
  logic [WIDTH-1:0] fold_s;
  logic             busy_s;
  logic             done_s;
  logic             pass_s;

  // Next-state and next-output computation; everything holds unless a
  // state rule below says otherwise.
  always_comb begin
    state_s    = state_r;
    skip_cnt_s = skip_cnt_r;
    vec_cnt_s  = vec_cnt_r;
    sig_s      = signature;
    busy_s     = busy;
    done_s     = done;
    pass_s     = pass;
    fold_s     = misr_step(signature, alu_out);

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sig_s      = SEED;
          vec_cnt_s  = num_vec;
          skip_cnt_s = SKIP_LD;
          done_s     = 1'b0;
          pass_s     = 1'b0;
          if (num_vec == {CNT_W{1'b0}}) begin
            // empty window: the seed itself is the final signature
            state_s = ST_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = (golden == SEED);
          end else if (SKIP_ZERO) begin
            state_s = ST_COMPACT;
            busy_s  = 1'b1;
          end else begin
            state_s = ST_SKIP;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end

      ST_SKIP: begin
        // alu_out still carries stale results from before the first vector
        skip_cnt_s = skip_cnt_r - 4'd1;
        if (skip_cnt_r == 4'd1) begin
          state_s = ST_COMPACT;
        end else begin
          state_s = ST_SKIP;
        end
      end

      ST_COMPACT: begin
        sig_s     = fold_s;
        vec_cnt_s = vec_cnt_r - CNT_ONE;
        if (vec_cnt_r == CNT_ONE) begin
          // verdict uses the value being folded on this very edge
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (fold_s == golden);
        end else begin
          state_s = ST_COMPACT;
        end
      end

      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs registered; reset overrides start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      skip_cnt_r <= 4'd0;
      vec_cnt_r  <= {CNT_W{1'b0}};
      signature  <= SEED;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state_r    <= state_s;
      skip_cnt_r <= skip_cnt_s;
      vec_cnt_r  <= vec_cnt_s;
      signature  <= sig_s;
      busy       <= busy_s;
      done       <= done_s;
      pass       <= pass_s;
    end
  end

endmodule

// File: tb/tb_alu_resp_misr.sv
// Bench for alu_resp_misr: directed scenarios plus randomized runs checked
// against a polynomial-arithmetic MISR model and cycle-window expectations.
module tb_alu_resp_misr;

  localparam int SKIP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] num_vec;
  logic [7:0] alu_drv;
  logic [7:0] golden;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] signature;
  logic [7:0] alu_out;

  // behavioural ALU: registered inputs, then 2-cycle compute-to-alu_out
  logic       use_alu = 1'b0;
  logic [7:0] a_in = 8'h00, b_in = 8'h00;
  logic       op_in = 1'b0;
  logic [7:0] a_q, b_q, mid_q, alu_pipe;
  logic       op_q;

  int n_cmp = 0;
  int n_bad = 0;

  alu_resp_misr dut (
    .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
    .alu_out(alu_out), .golden(golden), .busy(busy), .done(done),
    .pass(pass), .signature(signature)
  );

  always #5 clk = ~clk;

  // ALU pipeline model used by the end-to-end scenario
  always @(posedge clk) begin
    a_q      <= a_in;
    b_q      <= b_in;
    op_q     <= op_in;
    mid_q    <= op_q ? (a_q - b_q) : (a_q + b_q);
    alu_pipe <= mid_q;
  end

  assign alu_out = use_alu ? alu_pipe : alu_drv;

  // GF(2) multiply-by-x modulo x^8+x^4+x^3+x^2+1, then add the sample
  function automatic logic [7:0] ref_fold(input logic [7:0] s, input logic [7:0] d);
    int v;
    v = int'(s) * 2;
    if (v >= 256) v = v ^ 32'h11D;
    return 8'(v) ^ d;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; num_vec = 8'd0; golden = 8'h00; alu_drv = 8'hA5;
    tick; tick;
    reset = 1'b0;
    n_cmp++;
    if ({signature, busy, done, pass} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state got sig=%h b=%b d=%b p=%b exp sig=00 b=0 d=0 p=0",
               signature, busy, done, pass);
    end
    for (int i = 0; i < 6; i++) begin
      alu_drv = 8'($urandom);
      tick;
      n_cmp++;
      if ({signature, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL idle_hold i=%0d got sig=%h b=%b d=%b exp sig=00 b=0 d=0",
                 i, signature, busy, done);
      end
    end
  endtask

  task automatic test_single_fold;
    start = 1'b1; num_vec = 8'd1; golden = 8'h5A; alu_drv = 8'hFF;
    tick;                                   // edge k
    start = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL single_busy before edge k+%0d got b=%b d=%b exp b=1 d=0", e, busy, done);
      end
      alu_drv = (e == 3) ? 8'h5A : 8'hFF;
      tick;
    end
    alu_drv = 8'hFF;
    n_cmp++;
    if ({signature, busy, done, pass} !== {8'h5A, 1'b0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL single_result got sig=%h b=%b d=%b p=%b exp sig=5a b=0 d=1 p=1",
               signature, busy, done, pass);
    end
    tick; tick;
    n_cmp++;
    if ({signature, done, pass} !== {8'h5A, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL single_frozen got sig=%h d=%b p=%b exp sig=5a d=1 p=1", signature, done, pass);
    end
  endtask

  task automatic test_feedback;
    logic [7:0] g;
    for (int r = 0; r < 2; r++) begin
      g = (r == 0) ? 8'h1C : 8'h1D;
      start = 1'b1; num_vec = 8'd2; golden = g; alu_drv = 8'hFF;
      tick;
      start = 1'b0;
      tick; tick;                           // skip window
      alu_drv = 8'h80;
      tick;
      n_cmp++;
      if (signature !== 8'h80) begin
        n_bad++;
        $display("FAIL feedback_first r=%0d got sig=%h exp 80", r, signature);
      end
      alu_drv = 8'h01;
      tick;
      alu_drv = 8'hFF;
      n_cmp++;
      if ({signature, done, pass} !== {8'h1C, 1'b1, (r == 0)}) begin
        n_bad++;
        $display("FAIL feedback_final r=%0d got sig=%h d=%b p=%b exp sig=1c d=1 p=%b",
                 r, signature, done, pass, (r == 0));
      end
    end
  endtask

  task automatic test_zero_len_restart;
    start = 1'b1; num_vec = 8'd0; golden = 8'h00; alu_drv = 8'h77;
    tick;
    start = 1'b0;
    n_cmp++;
    if ({signature, busy, done, pass} !== {8'h00, 1'b0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL zero_len got sig=%h b=%b d=%b p=%b exp sig=00 b=0 d=1 p=1",
               signature, busy, done, pass);
    end
    start = 1'b1; num_vec = 8'd0; golden = 8'h42;
    tick;
    start = 1'b0;
    n_cmp++;
    if ({done, pass} !== {1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL zero_len_bad_golden got d=%b p=%b exp d=1 p=0", done, pass);
    end
    start = 1'b1; num_vec = 8'd1; golden = 8'h3C;
    tick;
    start = 1'b0;
    n_cmp++;
    if ({busy, done, pass} !== {1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL restart_clear got b=%b d=%b p=%b exp b=1 d=0 p=0", busy, done, pass);
    end
    tick; tick;
    alu_drv = 8'h3C;
    tick;
    alu_drv = 8'h77;
    n_cmp++;
    if ({signature, done, pass} !== {8'h3C, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL restart_final got sig=%h d=%b p=%b exp sig=3c d=1 p=1", signature, done, pass);
    end
  endtask

  task automatic test_abuse;
    // start held high through SKIP and COMPACT must not restart the run
    start = 1'b1; num_vec = 8'd4; golden = 8'h00; alu_drv = 8'h11;
    tick;                                   // edge k
    for (int e = 1; e <= 6; e++) begin
      start = 1'b1; num_vec = 8'd9; alu_drv = 8'(e);
      tick;
      n_cmp++;
      if (done !== (e == 6) || busy !== (e != 6)) begin
        n_bad++;
        $display("FAIL abuse_start edge k+%0d got d=%b b=%b exp d=%b b=%b",
                 e, done, busy, (e == 6), (e != 6));
      end
    end
    start = 1'b0;
    // reset at edge k+4 of a fresh run
    start = 1'b1; num_vec = 8'd4; alu_drv = 8'hC3;
    tick;
    start = 1'b0;
    tick; tick; tick;                       // k+1..k+3, one fold done
    reset = 1'b1;
    tick;                                   // edge k+4
    reset = 1'b0;
    n_cmp++;
    if ({signature, busy, done, pass} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL abuse_reset got sig=%h b=%b d=%b p=%b exp sig=00 b=0 d=0 p=0",
               signature, busy, done, pass);
    end
    for (int i = 0; i < 4; i++) tick;
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL abuse_reset_idle got d=%b b=%b exp d=0 b=0", done, busy);
    end
  endtask

  task automatic test_random_runs;
    int         n;
    logic [7:0] smp[$];
    logic [7:0] exp_sig, final_sig, gold_t;
    logic       exp_pass, exp_done;
    for (int r = 0; r < 12; r++) begin
      n = (r == 0) ? 255 : int'($urandom_range(1, 24));
      smp.delete();
      final_sig = 8'h00;
      for (int i = 0; i < n; i++) begin
        smp.push_back(8'($urandom));
        final_sig = ref_fold(final_sig, smp[i]);
      end
      exp_pass = ($urandom_range(0, 1) == 1);
      gold_t   = exp_pass ? final_sig : (final_sig ^ 8'($urandom_range(1, 255)));
      start = 1'b1; num_vec = 8'(n); golden = 8'($urandom); alu_drv = 8'($urandom);
      tick;
      n_cmp++;
      if ({signature, busy, done} !== {8'h00, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL rand_start r=%0d got sig=%h b=%b d=%b exp sig=00 b=1 d=0",
                 r, signature, busy, done);
      end
      exp_sig = 8'h00;
      for (int e = 1; e <= SKIP + n; e++) begin
        start   = ($urandom_range(0, 3) == 0);
        num_vec = 8'($urandom);
        golden  = (e == SKIP + n) ? gold_t : 8'($urandom);
        alu_drv = (e > SKIP) ? smp[e - SKIP - 1] : 8'($urandom);
        tick;
        if (e > SKIP) exp_sig = ref_fold(exp_sig, smp[e - SKIP - 1]);
        exp_done = (e == SKIP + n);
        n_cmp++;
        if (signature !== exp_sig || done !== exp_done || busy !== !exp_done) begin
          n_bad++;
          $display("FAIL rand_step r=%0d e=%0d got sig=%h d=%b b=%b exp sig=%h d=%b b=%b",
                   r, e, signature, done, busy, exp_sig, exp_done, !exp_done);
        end
      end
      start = 1'b0;
      n_cmp++;
      if (pass !== exp_pass) begin
        n_bad++;
        $display("FAIL rand_pass r=%0d got p=%b exp p=%b", r, pass, exp_pass);
      end
      alu_drv = 8'($urandom); golden = 8'($urandom);
      tick;
      n_cmp++;
      if ({signature, done, pass} !== {final_sig, 1'b1, exp_pass}) begin
        n_bad++;
        $display("FAIL rand_frozen r=%0d got sig=%h d=%b p=%b exp sig=%h d=1 p=%b",
                 r, signature, done, pass, final_sig, exp_pass);
      end
    end
  endtask

  task automatic test_alu_e2e;
    logic [7:0] va[16], vb[16];
    logic       vop[16];
    logic [7:0] exp_sig;
    exp_sig = 8'h00;
    for (int i = 0; i < 16; i++) begin
      va[i]  = 8'($urandom);
      vb[i]  = 8'($urandom);
      vop[i] = 1'($urandom);
      exp_sig = ref_fold(exp_sig, vop[i] ? 8'(va[i] - vb[i]) : 8'(va[i] + vb[i]));
    end
    use_alu = 1'b1;
    start = 1'b1; num_vec = 8'd16; golden = exp_sig;
    a_in = va[0]; b_in = vb[0]; op_in = vop[0];
    tick;                                   // edge k: start and vector 0
    start = 1'b0;
    for (int e = 1; e <= SKIP + 16; e++) begin
      if (e < 16) begin
        a_in = va[e]; b_in = vb[e]; op_in = vop[e];
      end else begin
        a_in = 8'($urandom); b_in = 8'($urandom); op_in = 1'($urandom);
      end
      tick;
    end
    n_cmp++;
    if ({signature, done, pass, busy} !== {exp_sig, 1'b1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL alu_e2e got sig=%h d=%b p=%b b=%b exp sig=%h d=1 p=1 b=0",
               signature, done, pass, busy, exp_sig);
    end
    use_alu = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_fold;
    test_feedback;
    test_zero_len_restart;
    test_abuse;
    test_random_runs;
    test_alu_e2e;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
